// File: rtl/clic_entry_ctrl.sv
// clic_entry_ctrl: per-source CLIC state, arbiter entries and the core req/ack/complete handshake.
// A threshold stack lets only strictly higher-priority sources preempt a running handler.
module clic_entry_ctrl #(
    parameter int NR_INDEX_BITS = 4,
    parameter int NR_PRIO_BITS  = 3,
    parameter int NEST_DEPTH    = 4,
    localparam int NR_SRC = 2 ** NR_INDEX_BITS,
    localparam int LW     = $clog2(NEST_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NR_SRC-1:0]              irq_in,
    input  logic                           cfg_we,
    input  logic [NR_INDEX_BITS-1:0]       cfg_index,
    input  logic [NR_PRIO_BITS-1:0]        cfg_prio,
    input  logic                           cfg_enable,
    input  logic                           cfg_edge,
    input  logic                           cfg_set_pend,
    input  logic                           cfg_clr_pend,
    output logic [NR_SRC*NR_PRIO_BITS-1:0] entries,
    input  logic                           arb_valid,
    input  logic [NR_INDEX_BITS-1:0]       arb_index,
    output logic                           irq_req,
    output logic [NR_INDEX_BITS-1:0]       irq_index,
    output logic [NR_PRIO_BITS-1:0]        irq_prio,
    input  logic                           irq_ack,
    input  logic                           irq_complete,
    output logic [NR_PRIO_BITS-1:0]        threshold,
    output logic [LW-1:0]                  nest_level,
    output logic                           cpl_err
);
    localparam logic [LW-1:0] DEPTH = LW'(NEST_DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                  state, state_next;
    logic [NR_PRIO_BITS-1:0] prio [NR_SRC];
    logic [NR_PRIO_BITS-1:0] stk [NEST_DEPTH];
    logic [NR_SRC-1:0]       pending, enable, edge_mode, prev_irq;
    logic [NR_SRC-1:0]       eligible, set_pend, clr_pend;
    logic                    go, ack, pop;

    assign irq_req = state == REQ;
    assign ack     = irq_req && irq_ack;
    assign pop     = irq_complete && nest_level != '0;
    assign go      = state == IDLE && arb_valid && eligible[arb_index] && nest_level < DEPTH;

    for (genvar g = 0; g < NR_SRC; g++) begin : g_src
        assign eligible[g] = pending[g] & enable[g] & (prio[g] > threshold);
        assign entries[g*NR_PRIO_BITS +: NR_PRIO_BITS] = eligible[g] ? prio[g] : '0;
        assign set_pend[g] = (irq_in[g] & ~prev_irq[g]) | (cfg_set_pend & (cfg_index == NR_INDEX_BITS'(g)));
        assign clr_pend[g] = (cfg_clr_pend & (cfg_index == NR_INDEX_BITS'(g))) |
                             (ack & (irq_index == NR_INDEX_BITS'(g)));
    end

    always_comb begin
        state_next = state;
        if (go)
            state_next = REQ;
        else if (irq_req && (ack || !eligible[irq_index]))
            state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            enable     <= '0;
            edge_mode  <= '0;
            prev_irq   <= '0;
            irq_index  <= '0;
            irq_prio   <= '0;
            threshold  <= '0;
            nest_level <= '0;
            cpl_err    <= 1'b0;
            for (int k = 0; k < NR_SRC; k++) prio[k] <= '0;
            for (int k = 0; k < NEST_DEPTH; k++) stk[k] <= '0;
        end else begin
            state    <= state_next;
            prev_irq <= irq_in;
            cpl_err  <= irq_complete && nest_level == '0;
            // set beats clear in edge mode; level mode just follows the line
            pending  <= (edge_mode & (set_pend | (pending & ~clr_pend))) | (~edge_mode & irq_in);
            if (go) begin
                irq_index <= arb_index;
                irq_prio  <= prio[arb_index];
            end
            if (cfg_we) begin
                prio[cfg_index]      <= cfg_prio;
                enable[cfg_index]    <= cfg_enable;
                edge_mode[cfg_index] <= cfg_edge;
            end
            threshold <= ack ? irq_prio : pop ? stk[0] : threshold;
            // ack together with a pop leaves the stack and depth untouched
            if (ack && !pop) begin
                stk[0] <= threshold;
                for (int k = 1; k < NEST_DEPTH; k++) stk[k] <= stk[k-1];
                nest_level <= nest_level + 1'b1;
            end else if (pop && !ack) begin
                for (int k = 0; k < NEST_DEPTH - 1; k++) stk[k] <= stk[k+1];
                stk[NEST_DEPTH-1] <= '0;
                nest_level <= nest_level - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_clic_entry_ctrl.sv
// tb_clic_entry_ctrl: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_clic_entry_ctrl;
    localparam int IB = 4, PB = 3, ND = 4, NS = 16, LW = 3;

    logic            clk = 1'b0, reset = 1'b1;
    logic [NS-1:0]   irq_in = '0;
    logic            cfg_we = 0, cfg_enable = 0, cfg_edge = 0, cfg_set_pend = 0, cfg_clr_pend = 0;
    logic [IB-1:0]   cfg_index = '0, arb_index = '0;
    logic [PB-1:0]   cfg_prio = '0;
    logic            arb_valid = 0, irq_ack = 0, irq_complete = 0;
    logic [NS*PB-1:0] entries;
    logic            irq_req, cpl_err;
    logic [IB-1:0]   irq_index;
    logic [PB-1:0]   irq_prio, threshold;
    logic [LW-1:0]   nest_level;

    int checks = 0, errors = 0;

    clic_entry_ctrl #(.NR_INDEX_BITS(IB), .NR_PRIO_BITS(PB), .NEST_DEPTH(ND)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .cfg_we(cfg_we), .cfg_index(cfg_index),
        .cfg_prio(cfg_prio), .cfg_enable(cfg_enable), .cfg_edge(cfg_edge),
        .cfg_set_pend(cfg_set_pend), .cfg_clr_pend(cfg_clr_pend), .entries(entries),
        .arb_valid(arb_valid), .arb_index(arb_index), .irq_req(irq_req), .irq_index(irq_index),
        .irq_prio(irq_prio), .irq_ack(irq_ack), .irq_complete(irq_complete),
        .threshold(threshold), .nest_level(nest_level), .cpl_err(cpl_err)
    );

    always #5 clk = ~clk;

    // reference model: source table, a queue as the threshold stack, and a request flag
    bit m_pend[NS], m_en[NS], m_edge[NS], m_prev[NS];
    int m_prio[NS];
    int stk[$];
    int m_thr, m_idx, m_iprio;
    bit m_req, m_cerr;

    function automatic bit elig(int i);
        return m_pend[i] && m_en[i] && m_prio[i] > m_thr;
    endfunction

    function automatic logic [NS*PB-1:0] exp_entries();
        logic [NS*PB-1:0] e = '0;
        for (int i = 0; i < NS; i++) if (elig(i)) e[i*PB +: PB] = PB'(m_prio[i]);
        return e;
    endfunction

    function automatic int winner();
        int w = -1;
        for (int i = 0; i < NS; i++) if (elig(i) && (w < 0 || m_prio[i] > m_prio[w])) w = i;
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_prev[i] = 0; m_prio[i] = 0;
        end
        stk.delete();
        m_thr = 0; m_idx = 0; m_iprio = 0; m_req = 0; m_cerr = 0;
    endtask

    task automatic model_step();
        bit np[NS];
        bit ack, go, drop, set, clr;
        ack = m_req && irq_ack;
        for (int i = 0; i < NS; i++) begin
            set = (irq_in[i] && !m_prev[i]) || (cfg_set_pend && int'(cfg_index) == i);
            clr = (cfg_clr_pend && int'(cfg_index) == i) || (ack && m_idx == i);
            np[i] = !m_edge[i] ? irq_in[i] : set ? 1'b1 : clr ? 1'b0 : m_pend[i];
        end
        go   = !m_req && arb_valid && elig(int'(arb_index)) && stk.size() < ND;
        drop = m_req && (ack || !elig(m_idx));
        m_cerr = irq_complete && stk.size() == 0;
        if (go) begin
            m_idx = int'(arb_index);
            m_iprio = m_prio[m_idx];
        end
        m_req = go || (m_req && !drop);
        if (irq_complete && stk.size() > 0) m_thr = stk.pop_back();
        if (ack) begin
            stk.push_back(m_thr);
            m_thr = m_iprio;
        end
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = np[i];
            m_prev[i] = irq_in[i];
        end
        if (cfg_we) begin
            m_prio[cfg_index] = int'(cfg_prio);
            m_en[cfg_index] = cfg_enable;
            m_edge[cfg_index] = cfg_edge;
        end
    endtask

    // one clock: advance the model with the inputs the DUT saw, then play the arbiter
    task automatic tick();
        int w;
        @(posedge clk);
        if (!reset) model_step();
        #1;
        w = winner();
        arb_valid = w >= 0;
        arb_index = IB'(w < 0 ? 0 : w);
    endtask

    task automatic clear_inputs();
        irq_in = '0; cfg_we = 0; cfg_index = '0; cfg_prio = '0; cfg_enable = 0; cfg_edge = 0;
        cfg_set_pend = 0; cfg_clr_pend = 0; irq_ack = 0; irq_complete = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        model_reset();
        tick();
        tick();
        reset = 0;
    endtask

    task automatic cfg(input int s, input int p, input bit en, input bit edg);
        cfg_we = 1; cfg_index = IB'(s); cfg_prio = PB'(p); cfg_enable = en; cfg_edge = edg;
        tick();
        cfg_we = 0;
    endtask

    task automatic pulse(input int s);
        irq_in[s] = 1'b1;
        tick();
        irq_in[s] = 1'b0;
    endtask

    task automatic ack_once();
        irq_ack = 1;
        tick();
        irq_ack = 0;
    endtask

    task automatic complete_once();
        irq_complete = 1;
        tick();
        irq_complete = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", irq_req); end
        checks++; if (irq_index !== '0 || irq_prio !== '0) begin errors++; $display("FAIL reset_idx_prio got %0d/%0d want 0/0", irq_index, irq_prio); end
        checks++; if (threshold !== '0 || nest_level !== '0) begin errors++; $display("FAIL reset_thr_nest got %0d/%0d want 0/0", threshold, nest_level); end
        checks++; if (entries !== '0 || cpl_err !== 1'b0) begin errors++; $display("FAIL reset_entries got %h/%0b want 0/0", entries, cpl_err); end
    endtask

    task automatic test_edge_request();
        do_reset();
        cfg(3, 5, 1, 1);
        pulse(3);
        checks++; if (entries[3*PB +: PB] !== 3'd5) begin errors++; $display("FAIL edge_entry3 got %0d want 5", entries[3*PB +: PB]); end
        tick();
        checks++; if (irq_req !== 1'b1 || irq_index !== 4'd3 || irq_prio !== 3'd5) begin errors++; $display("FAIL edge_req got req=%0b idx=%0d prio=%0d want 1/3/5", irq_req, irq_index, irq_prio); end
        ack_once();
        checks++; if (entries[3*PB +: PB] !== 3'd0 || irq_req !== 1'b0) begin errors++; $display("FAIL edge_ack_clear got entry=%0d req=%0b want 0/0", entries[3*PB +: PB], irq_req); end
        checks++; if (threshold !== 3'd5 || nest_level !== 3'd1) begin errors++; $display("FAIL edge_ack_push got thr=%0d nest=%0d want 5/1", threshold, nest_level); end
    endtask

    // continues from test_edge_request: threshold 5, one level deep
    task automatic test_nesting();
        cfg(7, 3, 1, 1);
        cfg(9, 6, 1, 1);
        irq_in[7] = 1; irq_in[9] = 1;
        tick();
        irq_in = '0;
        checks++; if (entries[7*PB +: PB] !== 3'd0 || entries[9*PB +: PB] !== 3'd6) begin errors++; $display("FAIL nest_entries got e7=%0d e9=%0d want 0/6", entries[7*PB +: PB], entries[9*PB +: PB]); end
        tick();
        checks++; if (irq_req !== 1'b1 || irq_index !== 4'd9 || irq_prio !== 3'd6) begin errors++; $display("FAIL nest_req got req=%0b idx=%0d prio=%0d want 1/9/6", irq_req, irq_index, irq_prio); end
        ack_once();
        checks++; if (threshold !== 3'd6 || nest_level !== 3'd2) begin errors++; $display("FAIL nest_push got thr=%0d nest=%0d want 6/2", threshold, nest_level); end
        complete_once();
        checks++; if (threshold !== 3'd5 || nest_level !== 3'd1) begin errors++; $display("FAIL nest_pop1 got thr=%0d nest=%0d want 5/1", threshold, nest_level); end
        complete_once();
        checks++; if (threshold !== 3'd0 || nest_level !== 3'd0) begin errors++; $display("FAIL nest_pop2 got thr=%0d nest=%0d want 0/0", threshold, nest_level); end
    endtask

    task automatic test_withdraw();
        do_reset();
        cfg(2, 4, 1, 1);
        pulse(2);
        tick();
        checks++; if (irq_req !== 1'b1 || irq_index !== 4'd2) begin errors++; $display("FAIL wd_req got req=%0b idx=%0d want 1/2", irq_req, irq_index); end
        cfg_clr_pend = 1; cfg_index = 4'd2;
        tick();
        cfg_clr_pend = 0;
        tick();
        checks++; if (irq_req !== 1'b0 || entries[2*PB +: PB] !== 3'd0) begin errors++; $display("FAIL wd_drop got req=%0b entry=%0d want 0/0", irq_req, entries[2*PB +: PB]); end
        checks++; if (threshold !== 3'd0 || nest_level !== 3'd0) begin errors++; $display("FAIL wd_thr got thr=%0d nest=%0d want 0/0", threshold, nest_level); end
        pulse(2);
        tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL wd_rerequest got %0b want 1", irq_req); end
    endtask

    task automatic test_stack_full();
        do_reset();
        for (int s = 1; s <= 4; s++) cfg(s, s, 1, 1);
        for (int s = 1; s <= 4; s++) begin
            pulse(s);
            tick();
            checks++; if (irq_req !== 1'b1 || irq_index !== IB'(s)) begin errors++; $display("FAIL fill_req%0d got req=%0b idx=%0d want 1/%0d", s, irq_req, irq_index, s); end
            ack_once();
        end
        checks++; if (threshold !== 3'd4 || nest_level !== 3'd4) begin errors++; $display("FAIL fill_full got thr=%0d nest=%0d want 4/4", threshold, nest_level); end
        cfg(10, 7, 1, 1);
        pulse(10);
        checks++; if (entries[10*PB +: PB] !== 3'd7) begin errors++; $display("FAIL full_entry10 got %0d want 7", entries[10*PB +: PB]); end
        repeat (3) begin
            tick();
            checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL full_blocked got req=%0b want 0", irq_req); end
        end
        complete_once();
        checks++; if (threshold !== 3'd3 || nest_level !== 3'd3) begin errors++; $display("FAIL full_pop got thr=%0d nest=%0d want 3/3", threshold, nest_level); end
        tick();
        checks++; if (irq_req !== 1'b1 || irq_index !== 4'd10 || irq_prio !== 3'd7) begin errors++; $display("FAIL full_release got req=%0b idx=%0d prio=%0d want 1/10/7", irq_req, irq_index, irq_prio); end
        do_reset();
        complete_once();
        checks++; if (cpl_err !== 1'b1 || nest_level !== 3'd0) begin errors++; $display("FAIL cpl_err_pulse got err=%0b nest=%0d want 1/0", cpl_err, nest_level); end
        tick();
        checks++; if (cpl_err !== 1'b0) begin errors++; $display("FAIL cpl_err_one_cycle got %0b want 0", cpl_err); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        cfg(5, 3, 1, 1);
        pulse(5);
        tick();
        irq_in[5] = 1; irq_ack = 1;
        tick();
        irq_in[5] = 0; irq_ack = 0;
        checks++; if (threshold !== 3'd3 || nest_level !== 3'd1) begin errors++; $display("FAIL setclr_ack got thr=%0d nest=%0d want 3/1", threshold, nest_level); end
        complete_once();
        checks++; if (entries[5*PB +: PB] !== 3'd3) begin errors++; $display("FAIL setclr_pending got entry5=%0d want 3", entries[5*PB +: PB]); end
        do_reset();
        cfg(1, 2, 1, 1);
        cfg(6, 5, 1, 1);
        pulse(1);
        tick();
        ack_once();
        pulse(6);
        tick();
        checks++; if (irq_req !== 1'b1 || irq_index !== 4'd6) begin errors++; $display("FAIL ackcpl_req got req=%0b idx=%0d want 1/6", irq_req, irq_index); end
        irq_ack = 1; irq_complete = 1;
        tick();
        irq_ack = 0; irq_complete = 0;
        checks++; if (threshold !== 3'd5 || nest_level !== 3'd1 || irq_req !== 1'b0) begin errors++; $display("FAIL ackcpl got thr=%0d nest=%0d req=%0b want 5/1/0", threshold, nest_level, irq_req); end
        complete_once();
        checks++; if (threshold !== 3'd0 || nest_level !== 3'd0) begin errors++; $display("FAIL ackcpl_unwind got thr=%0d nest=%0d want 0/0", threshold, nest_level); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cfg(3, 2, 1, 1);
        cfg(4, 6, 1, 1);
        pulse(3);
        tick();
        ack_once();
        pulse(4);
        tick();
        checks++; if (irq_req !== 1'b1 || threshold !== 3'd2) begin errors++; $display("FAIL arst_setup got req=%0b thr=%0d want 1/2", irq_req, threshold); end
        #1 reset = 1;
        #2;
        checks++; if (irq_req !== 1'b0 || threshold !== 3'd0 || nest_level !== 3'd0) begin errors++; $display("FAIL arst_now got req=%0b thr=%0d nest=%0d want 0/0/0", irq_req, threshold, nest_level); end
        checks++; if (entries !== '0) begin errors++; $display("FAIL arst_entries got %h want 0", entries); end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        repeat (3000) begin
            for (int i = 0; i < NS; i++) if ($urandom_range(7) == 0) irq_in[i] = ~irq_in[i];
            cfg_we       = $urandom_range(5) == 0;
            cfg_index    = IB'($urandom_range(NS - 1));
            cfg_prio     = PB'($urandom_range(7));
            cfg_enable   = $urandom_range(3) != 0;
            cfg_edge     = $urandom_range(1) == 1;
            cfg_set_pend = $urandom_range(9) == 0;
            cfg_clr_pend = $urandom_range(9) == 0;
            irq_ack      = $urandom_range(2) == 0;
            irq_complete = $urandom_range(7) == 0;
            if ($urandom_range(9) == 0) begin
                arb_valid = $urandom_range(1) == 1;
                arb_index = IB'($urandom_range(NS - 1));
            end
            tick();
            checks++; if (entries !== exp_entries()) begin errors++; $display("FAIL rnd_entries got %h want %h", entries, exp_entries()); end
            checks++; if (irq_req !== m_req) begin errors++; $display("FAIL rnd_req got %0b want %0b", irq_req, m_req); end
            checks++; if (irq_index !== IB'(m_idx) || irq_prio !== PB'(m_iprio)) begin errors++; $display("FAIL rnd_idx_prio got %0d/%0d want %0d/%0d", irq_index, irq_prio, m_idx, m_iprio); end
            checks++; if (threshold !== PB'(m_thr)) begin errors++; $display("FAIL rnd_thr got %0d want %0d", threshold, m_thr); end
            checks++; if (nest_level !== LW'(stk.size())) begin errors++; $display("FAIL rnd_nest got %0d want %0d", nest_level, stk.size()); end
            checks++; if (cpl_err !== m_cerr) begin errors++; $display("FAIL rnd_cpl_err got %0b want %0b", cpl_err, m_cerr); end
        end
    endtask

    initial begin
        test_reset();
        test_edge_request();
        test_nesting();
        test_withdraw();
        test_stack_full();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
